// File: rtl/alu_mdu_seq_pkg.sv
// Shared definitions for the sequential ALU/MDU: base ALU codes, RV32M funct3 values,
// FSM state encoding and the M-extension operation decoder.
package alu_mdu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] ALU_LUI  = 4'hA;

    localparam logic [2:0] M_MUL    = 3'd0;
    localparam logic [2:0] M_MULH   = 3'd1;
    localparam logic [2:0] M_MULHSU = 3'd2;
    localparam logic [2:0] M_MULHU  = 3'd3;
    localparam logic [2:0] M_DIV    = 3'd4;
    localparam logic [2:0] M_DIVU   = 3'd5;
    localparam logic [2:0] M_REM    = 3'd6;
    localparam logic [2:0] M_REMU   = 3'd7;

    // sel_hi picks the upper product half for MULH*, and the remainder for REM*
    typedef struct packed {
        logic is_div;
        logic sel_hi;
        logic a_signed;
        logic b_signed;
    } mdec_t;

    function automatic mdec_t m_decode(input logic [2:0] f3);
        mdec_t d;
        d.is_div   = f3[2];
        d.sel_hi   = f3[2] ? f3[1] : (f3[1:0] != 2'b00);
        d.a_signed = f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
        d.b_signed = f3[2] ? ~f3[0] : (f3[1:0] <= 2'b01);
        return d;
    endfunction

endpackage

// File: rtl/alu_mdu_seq_muldiv_iter.sv
// Radix-2 iterative engine on unsigned magnitudes: shift-add multiply or restoring divide,
// one bit per step, sharing a single 2*XLEN accumulator.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              done_o,
    output logic [2*XLEN-1:0] acc_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     mul_sum, div_trial, div_diff;

    // Multiply: {hi, multiplier} shifts right, multiplicand added into hi.
    // Divide: {remainder, dividend} shifts left, quotient bits enter at the LSB.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & b_q};
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, b_q};
        acc_d     = acc_q;
        b_d       = b_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        if (start_i) begin
            acc_d = {{XLEN{1'b0}}, a_i};
            b_d   = b_i;
            div_d = is_div_i;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                if (!div_diff[XLEN]) begin
                    acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = step_i && (cnt_q == CNT_W'(XLEN - 1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage execution unit: single-cycle RV32I base ALU plus iterative RV32M multiply/divide,
// with valid/ready handshakes on both operand and result sides.
module alu_mdu_seq
    import alu_mdu_seq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op_func,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              is_div_q, sel_hi_q, neg_q;

    logic              accept, is_m, m_special, div_zero, div_ovf;
    logic              a_neg, b_neg, neg_in;
    mdec_t             dec_in;
    logic [XLEN-1:0]   a_mag, b_mag, alu_res, special_res, fix_res, div_v;
    logic [SHAMT_W-1:0] shamt;
    logic [2*XLEN-1:0] eng_acc, prod;
    logic              eng_start, eng_step, eng_done;

    assign accept   = in_valid && in_ready && !flush;
    assign is_m     = op_func[4];
    assign dec_in   = m_decode(op_func[2:0]);
    assign div_zero = is_m && dec_in.is_div && (op2 == '0);
    assign div_ovf  = is_m && dec_in.is_div && dec_in.a_signed &&
                      (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign m_special = div_zero || div_ovf;

    assign a_neg  = dec_in.a_signed && op1[XLEN-1];
    assign b_neg  = dec_in.b_signed && op2[XLEN-1];
    assign a_mag  = a_neg ? -op1 : op1;
    assign b_mag  = b_neg ? -op2 : op2;
    // Remainder follows the dividend's sign; quotient and product follow the sign product
    assign neg_in = (dec_in.is_div && dec_in.sel_hi) ? a_neg : (a_neg ^ b_neg);

    assign special_res = div_zero ? (dec_in.sel_hi ? op1 : '1)
                                  : (dec_in.sel_hi ? '0 : op1);

    assign shamt = op2[SHAMT_W-1:0];

    always_comb begin
        case (op_func[3:0])
            ALU_ADD:  alu_res = op1 + op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_SLL:  alu_res = op1 << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_SRL:  alu_res = op1 >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op1) >>> shamt);
            ALU_OR:   alu_res = op1 | op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_LUI:  alu_res = op2;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        prod    = neg_q ? -eng_acc : eng_acc;
        div_v   = sel_hi_q ? eng_acc[2*XLEN-1:XLEN] : eng_acc[XLEN-1:0];
        fix_res = '0;
        if (is_div_q) begin
            fix_res = neg_q ? -div_v : div_v;
        end else begin
            fix_res = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (eng_start),
        .step_i   (eng_step),
        .is_div_i (dec_in.is_div),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .done_o   (eng_done),
        .acc_o    (eng_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (is_m && !m_special) ? ST_CALC : ST_DONE;
            ST_CALC:  if (flush) state_d = ST_IDLE;
                      else if (eng_done) state_d = ST_FIXUP;
            ST_FIXUP: state_d = flush ? ST_IDLE : ST_DONE;
            ST_DONE:  if (flush || out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        eng_start = accept && is_m && !m_special;
        eng_step  = (state_q == ST_CALC);
    end

    // Result is only written on a completing accept or at FIXUP, never mid-iteration
    always_comb begin
        result_d = result_q;
        if (accept) begin
            if (!is_m) begin
                result_d = alu_res;
            end else if (m_special) begin
                result_d = special_res;
            end
        end else if (state_q == ST_FIXUP && !flush) begin
            result_d = fix_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            if (accept) begin
                is_div_q <= dec_in.is_div;
                sel_hi_q <= dec_in.sel_hi;
                neg_q    <= neg_in;
            end
        end
    end

    assign result = result_q;

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised sequential execution unit: next-generation EX-stage arithmetic block.
- Performs all base RV32I ALU operations plus the RV32M multiply/divide set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Operands are accepted over a valid/ready handshake. Results are returned over a second valid/ready handshake.
- Base ops complete in one cycle. Multiply and divide run on an iterative radix-2 engine, so the pipeline stalls on in_ready.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- SHAMT_W, $clog2(XLEN), number of op2 LSBs used as shift amount.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous cancel of any operation in flight
- in_valid  in  1  operand/func presented
- in_ready  out  1  unit can accept
- op_func  in  5  [4]=0: base ALU, [3:0] = shared ALU code; [4]=1: M-ext, [2:0] = funct3
- op1  in  XLEN  first operand
- op2  in  XLEN  second operand / immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result=0; counter and accumulators cleared.
- Accept: accept on the clk edge with in_valid&&in_ready (call it cycle 0). op1, op2 and op_func are latched, so inputs may change afterwards.
- in_ready = (state==IDLE). There is no acceptance in any other state.
- States:
  - IDLE: on accept, go to DONE for base ops and M special cases, else CALC.
  - CALC: counter runs XLEN iterations, then goes to FIXUP.
  - FIXUP: sign correction and high/low select, one cycle, then DONE.
  - DONE: out_valid=1 and result is held stable until out_ready=1. On out_ready, go to IDLE.
- Latency:
  - Base op: out_valid at cycle 1.
  - MUL*/DIV*/REM*: out_valid at cycle XLEN+2 (34 for XLEN=32).
  - Div special cases: out_valid at cycle 1.
- Base ops use shared codes SLL, SRL, SRA, ADD, SUB, XOR, OR, AND, SLT, SLTU, LUI:
  - Shifts use op2[SHAMT_W-1:0]. SRA is arithmetic.
  - SLT/SLTU return 1 or 0.
  - LUI returns op2.
  - An unlisted code returns 0, never X.
- Multiply:
  - Operands are converted to magnitudes per signedness: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Shift-add runs one bit per cycle into a 2*XLEN accumulator.
  - FIXUP negates the product if the operand signs differ.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - FIXUP: quotient is negated if signs differ (signed ops); remainder takes the dividend's sign.
- Div special cases (bypass CALC):
  - op2==0: DIV/DIVU return all-ones; REM/REMU return op1.
  - Signed overflow (op1 = most-negative, op2 = -1): DIV returns op1, REM returns 0.
- flush:
  - In CALC/FIXUP/DONE: go to IDLE next cycle and drop out_valid.
  - In IDLE: no effect, and suppresses an acceptance in the same cycle.
- Reset mid-operation: immediate return to reset values. No partial result escapes.
- Backpressure: while out_ready=0 in DONE, result and out_valid stay constant indefinitely.

Decomposition:
- Shared package (extends the existing parameters header):
  - base ALU func codes;
  - M-ext funct3 constants: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7;
  - state encoding IDLE/CALC/FIXUP/DONE.
- One natural sub-module, muldiv_iter: iterative multiply/divide engine with start, counter and accumulator, driven by the top-level FSM.
- The base-op datapath stays inline as a combinational case.

Test Plan:
- Base ops: ADD op1=0x7FFFFFFF, op2=1 -> result 0x80000000 at cycle 1. SRA 0x80000000 by 4 -> 0xF8000000. SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- Multiply: MULH 0x80000000×0x80000000 -> 0x40000000 at cycle 34. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MUL 7×-3 -> 0xFFFFFFEB.
- Divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; all at cycle 34.
- Special cases: DIV 5/0 -> 0xFFFFFFFF at cycle 1. REMU 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0. Then out_ready=1 -> out_valid drops next cycle and in_ready rises.
- flush and reset mid-operation: flush at cycle 10 of a DIV -> out_valid never asserts for it and in_ready=1 at cycle 11. Async rst_n pulse mid-MUL -> outputs return to reset values immediately and the next op returns a correct result.
